alu4_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter for the shared 4-bit ALU. It accepts operation requests from two clients, configures the ALU (operands, op select, carry-in), registers the result and flags, and returns them with the winning client's ID. It sits between the NPC's requesting units and the single combinational `ALU4` instance.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu4_arbiter.sv | 124 ++++++++++++
 tb/tb_alu4_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU sequencer: op encodings, FSM states,
// and the carry-in rule for the subtract-based ops.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // The ALU forms a + ~b + 1 for these ops, so they need carry-in set.
  function automatic logic cin_for_op(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. A tie goes to the client that did not win
// last; last_grant resets to 1 so client 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu4_arbiter.sv
// Sequencer plus two-client round-robin front end for the shared combinational
// 4-bit ALU: accept one request, run it for one cycle, return registered result.
module alu4_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic [1:0]       state_dbg
);

  // Handshake: a request transfers on a rising edge where reqN_valid and
  // reqN_ready are both 1; a response retires on an edge where rsp_valid and
  // rsp_ready are both 1. Requesters keep valid and operands stable until ready.

  state_t           state_q, state_d;
  logic [1:0]       grant;
  logic             arb_en;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             id_q;

  assign arb_en = (state_q == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_cin   = cin_for_op(op_q);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture happens only on a grant, so alu_* never see the live
  // request ports and stay stable for the full EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= grant[1] ? req1_a  : req0_a;
      b_q  <= grant[1] ? req1_b  : req0_b;
      op_q <= grant[1] ? req1_op : req0_op;
      id_q <= grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= id_q;
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
      rsp_carry    <= alu_carry;
    end else if ((state_q == HOLD) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed bench for alu4_arbiter with a behavioural 4-bit ALU standing in
// for the external ALU4 instance.
module tb_alu4_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_carry;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_cin, alu_zero, alu_overflow, alu_carry;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  alu4_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  // ---- behavioural ALU ----
  logic [3:0] bb;
  logic [4:0] sum5;
  logic       ov;
  always_comb begin
    bb           = alu_cin ? ~alu_b : alu_b;
    sum5         = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
    ov           = (alu_a[3] == bb[3]) && (sum5[3] != alu_a[3]);
    alu_result   = sum5[3:0];
    alu_carry    = sum5[4];
    alu_overflow = ov;
    case (alu_op)
      OP_NOT: begin alu_result = ~alu_a;          alu_carry = 1'b0; alu_overflow = 1'b0; end
      OP_AND: begin alu_result = alu_a & alu_b;   alu_carry = 1'b0; alu_overflow = 1'b0; end
      OP_OR:  begin alu_result = alu_a | alu_b;   alu_carry = 1'b0; alu_overflow = 1'b0; end
      OP_XOR: begin alu_result = alu_a ^ alu_b;   alu_carry = 1'b0; alu_overflow = 1'b0; end
      OP_SLT: alu_result = {3'b000, sum5[3] ^ ov};
      OP_EQ:  alu_result = {3'b000, sum5[3:0] == 4'd0};
      default: ;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  // ---- checking ----
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- drivers ----
  task automatic drive(input int cl, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] op);
    if (cl == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request, checks the EXEC cycle and the response two cycles
  // after accept. Leaves rsp_ready at the value given.
  task automatic run_op(input string tag, input int cl, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic ez, input logic ev,
                        input logic ec, input logic ecin, input logic rdy);
    bit got;
    got = 0;
    @(negedge clk);
    rsp_ready = rdy;
    drive(cl, 1'b1, a, b, op);
    for (int t = 0; t < 8 && !got; t++) begin
      #1;
      if ((cl == 0) ? req0_ready : req1_ready) got = 1;
      else @(negedge clk);
    end
    check({tag, "_accept"}, int'(got), 1);
    @(negedge clk);
    drive(cl, 1'b0, 4'd0, 4'd0, 3'd0);
    #1;
    check({tag, "_exec_state"}, int'(state_dbg), int'(EXEC));
    check({tag, "_alu_a"}, int'(alu_a), int'(a));
    check({tag, "_alu_b"}, int'(alu_b), int'(b));
    check({tag, "_alu_cin"}, int'(alu_cin), int'(ecin));
    check({tag, "_no_early_rsp"}, int'(rsp_valid), 0);
    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"}, int'(rsp_valid), 1);
    check({tag, "_rsp_id"}, int'(rsp_id), cl);
    check({tag, "_result"}, int'(rsp_result), int'(er));
    check({tag, "_zero"}, int'(rsp_zero), int'(ez));
    check({tag, "_ovf"}, int'(rsp_overflow), int'(ev));
    check({tag, "_carry"}, int'(rsp_carry), int'(ec));
  endtask

  // ---- stimulus ----
  int extra;
  int nrsp;
  int last_cyc;
  logic [4:0] e;

  initial begin
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", int'(req0_ready), 0);
    check("rst_ready1", int'(req1_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_alu", int'({alu_a, alu_b, alu_op, alu_cin}), 0);
    check("rst_rsp", int'({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carry}), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    // add 7+1, sub 3-3, slt -2<1, eq 5==5
    run_op("add", 0, 4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("add_rsp_one_cycle", int'(rsp_valid), 0);
    run_op("sub", 1, 4'b0011, 4'b0011, OP_SUB, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op("slt", 0, 4'b1110, 4'b0001, OP_SLT, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op("eq",  1, 4'b0101, 4'b0101, OP_EQ,  4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // backpressure: 4|2 held for five stall cycles with both clients pushing
    run_op("bp", 0, 4'b0100, 4'b0010, OP_OR, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 4'd1, 4'd1, OP_ADD);
    drive(1, 1'b1, 4'd2, 4'd2, OP_ADD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", int'(rsp_valid), 1);
      check("bp_hold_rsp", int'({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carry}),
            int'({1'b0, 4'b0110, 3'b000}));
      check("bp_ready", int'({req1_ready, req0_ready}), 0);
    end
    drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
    rsp_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) extra++;
    end
    check("bp_single_rsp", extra, 0);

    // reset during EXEC of a client-0 sub; last_grant was 0 just before reset
    @(negedge clk);
    drive(0, 1'b1, 4'b1001, 4'b0110, OP_SUB);
    #1;
    check("rmo_accept", int'(req0_ready), 1);
    @(negedge clk);
    drive(1, 1'b1, 4'b0011, 4'b0001, OP_ADD);
    #1;
    check("rmo_exec", int'(state_dbg), int'(EXEC));
    check("rmo_cin", int'(alu_cin), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rmo_no_rsp", int'(rsp_valid), 0);
    check("rmo_alu", int'({alu_a, alu_b, alu_op, alu_cin}), 0);
    check("rmo_rsp", int'({rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_carry}), 0);
    check("rmo_ready_in_rst", int'({req1_ready, req0_ready}), 0);
    check("rmo_state", int'(state_dbg), int'(IDLE));
    rst = 1'b0;
    #1;
    check("rmo_tie_to_0", int'({req1_ready, req0_ready}), 1);
    drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    do_reset();

    // contention: both valid continuously, grants alternate starting at 0
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b1, 4'd5});
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b1, 4'd5});
    rsp_ready = 1'b1;
    drive(0, 1'b1, 4'd1, 4'd1, OP_ADD);
    drive(1, 1'b1, 4'd6, 4'd3, OP_XOR);
    nrsp = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
        check("cont_rsp", int'({rsp_id, rsp_result}), int'(e));
        if (nrsp > 0) check("cont_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        nrsp++;
      end
    end
    check("cont_count", nrsp, 4);
    check("cont_q_empty", exp_q.size(), 0);
    drive(0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 4'd0, 4'd0, 3'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
